// File: rtl/keypad_scanner.sv
// 3x4 matrix keypad scanner: strobes one column at a time, collects a full
// frame of row samples, rejects multi-key frames and debounces the result.
module keypad_scanner #(
    parameter int COL_HOLD = 2,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] key_col,
    input  logic [3:0] key_row,
    output logic [9:0] keypad,
    output logic       key_star,
    output logic       key_hash,
    output logic [3:0] key_code,
    output logic       key_press
);

    localparam int HW = $clog2(COL_HOLD);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(COL_HOLD - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE);
    localparam logic [3:0]    CODE_NONE = 4'd15;

    typedef enum logic [1:0] {COL0, COL1, COL2} state_t;

    state_t        state_q;
    logic [HW-1:0] hold_q;
    logic [2:0]    col_q;
    logic [3:0]    rows0_q;
    logic [3:0]    rows1_q;
    logic [3:0]    cand_q;
    logic [3:0]    cand_d;
    logic [DW-1:0] count_q;
    logic [DW-1:0] count_d;
    logic          accept_q;
    logic          accept_d;
    logic [3:0]    code_q;
    logic          press_q;

    logic          sample_last;
    logic          frame_end;
    logic [3:0]    frame_result;
    logic [3:0]    hits;
    logic [3:0]    found;
    logic [3:0]    col_rows;

    function automatic logic [3:0] code_at(input int r, input int c);
        if (r == 3) begin
            return (c == 0) ? 4'd10 : (c == 1) ? 4'd0 : 4'd11;
        end
        return 4'(r * 3 + c + 1);
    endfunction

    assign sample_last = (hold_q == HOLD_LAST);
    assign frame_end   = (state_q == COL2) && sample_last;

    // The third column is taken live from key_row on the COL2 sample cycle.
    always_comb begin
        hits     = '0;
        found    = CODE_NONE;
        col_rows = '0;
        for (int c = 0; c < 3; c++) begin
            col_rows = (c == 0) ? rows0_q : (c == 1) ? rows1_q : ~key_row;
            for (int r = 0; r < 4; r++) begin
                if (col_rows[r]) begin
                    hits  = hits + 4'd1;
                    found = code_at(r, c);
                end
            end
        end
        frame_result = (hits == 4'd1) ? found : CODE_NONE;
    end

    // Accept fires only on the frame where the count first reaches DEBOUNCE.
    always_comb begin
        cand_d   = cand_q;
        count_d  = count_q;
        accept_d = 1'b0;
        if (frame_end) begin
            if (frame_result == cand_q) begin
                if (count_q != DB_MAX) begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                cand_d  = frame_result;
                count_d = DW'(1);
            end
            accept_d = (count_d == DB_MAX) &&
                       ((count_q != DB_MAX) || (frame_result != cand_q));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= COL0;
            hold_q   <= '0;
            col_q    <= 3'b110;
            rows0_q  <= '0;
            rows1_q  <= '0;
            cand_q   <= CODE_NONE;
            count_q  <= '0;
            accept_q <= 1'b0;
            code_q   <= CODE_NONE;
            press_q  <= 1'b0;
        end else begin
            if (sample_last) begin
                hold_q <= '0;
                case (state_q)
                    COL0: begin
                        state_q <= COL1;
                        col_q   <= 3'b101;
                        rows0_q <= ~key_row;
                    end
                    COL1: begin
                        state_q <= COL2;
                        col_q   <= 3'b011;
                        rows1_q <= ~key_row;
                    end
                    default: begin
                        state_q <= COL0;
                        col_q   <= 3'b110;
                    end
                endcase
            end else begin
                hold_q <= hold_q + 1'b1;
            end
            cand_q   <= cand_d;
            count_q  <= count_d;
            accept_q <= accept_d;
            press_q  <= 1'b0;
            if (accept_q) begin
                code_q  <= cand_q;
                press_q <= (cand_q != CODE_NONE) && (cand_q != code_q);
            end
        end
    end

    assign key_col   = col_q;
    assign key_code  = code_q;
    assign key_press = press_q;
    assign key_star  = (code_q == 4'd10);
    assign key_hash  = (code_q == 4'd11);
    assign keypad    = (code_q <= 4'd9) ? (10'b1 << code_q) : '0;

endmodule
